key_event_queue: RTL and testbench

- Sits directly downstream of the PS/2 keyboard decoder.
- Consumes its level-held 16-bit key code: non-zero while a key is down, 0 when no key is down.
- Converts that level into discrete key events, with typematic auto-repeat.
- Buffers the events in a small FIFO so the CPU-side memory-mapped keyboard register can pop keys without losing fast keystrokes.

---
 rtl/key_event_queue.sv | 154 +++++++++++++++
 tb/tb_key_event_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// Key event queue: turns the decoder's level-held key code into press and
// typematic repeat events, buffered in a small FIFO for the CPU to pop.
//   clk, resetn     : clock, async active-low reset
//   key_in[15:0]    : level key code, only [7:0] used, 0 = no key down
//   pop, ovf_clear  : remove head entry / clear sticky overflow
//   out, empty, full, overflow : {8'b0, head} (0 when empty), FIFO status
module key_event_queue #(
   parameter int DEPTH         = 8,
   parameter int REPEAT_DELAY  = 12562500,
   parameter int REPEAT_PERIOD = 837500
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] key_in,
   input  logic        pop,
   input  logic        ovf_clear,
   output logic [15:0] out,
   output logic        empty,
   output logic        full,
   output logic        overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(MAXR) + 1;

   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic [7:0]    prev_q, prev_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    mem_q [DEPTH];

   logic [7:0] key;
   logic       press;
   logic       push;
   logic [7:0] push_data;
   logic       do_pop;
   logic       do_push;
   logic       drop;
   logic       unused_hi;

   // Extended-code byte is already folded into [7:0] by the decoder.
   assign unused_hi = ^key_in[15:8];

   assign key   = key_in[7:0];
   assign press = (key != 8'h00) && (key != prev_q);

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      push      = 1'b0;
      push_data = key;
      prev_d    = key;
      if (key == 8'h00) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end else if (press) begin
         push    = 1'b1;
         state_d = DELAY;
         rcnt_d  = '0;
      end else begin
         unique case (state_q)
            DELAY: begin
               if (rcnt_q == DLY_LAST) begin
                  push      = 1'b1;
                  push_data = prev_q;
                  rcnt_d    = '0;
                  state_d   = REPEAT;
               end else begin
                  rcnt_d = rcnt_q + CW'(1);
               end
            end
            REPEAT: begin
               if (rcnt_q == PER_LAST) begin
                  push      = 1'b1;
                  push_data = prev_q;
                  rcnt_d    = '0;
               end else begin
                  rcnt_d = rcnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);

   // A pop frees the slot, so a push into a full FIFO with a pop succeeds.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
      if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
      // Set beats clear when both happen together.
      if (drop) ovf_d = 1'b1;
      else if (ovf_clear) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         rcnt_q   <= '0;
         prev_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         prev_q   <= prev_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; count_q gates what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign out      = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
   assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus random key/pop traffic
// checked against a queue-based event model.
module tb_key_event_queue;

   localparam int DEPTH = 8;
   localparam int RD    = 20;
   localparam int RP    = 5;

   logic        clk;
   logic        resetn;
   logic [15:0] key_in;
   logic        pop;
   logic        ovf_clear;
   logic [15:0] out;
   logic        empty;
   logic        full;
   logic        overflow;

   key_event_queue #(
      .DEPTH(DEPTH),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .key_in(key_in),
      .pop(pop),
      .ovf_clear(ovf_clear),
      .out(out),
      .empty(empty),
      .full(full),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m_prev;
   int         m_t;
   logic [7:0] m_q[$];
   logic       m_ovf;

   function automatic logic [18:0] m_exp();
      logic [15:0] o;
      o = (m_q.size() > 0) ? {8'h00, m_q[0]} : 16'h0000;
      return {o, m_q.size() == 0, m_q.size() == DEPTH, m_ovf};
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_prev = 8'h00;
      m_t    = 0;
      m_ovf  = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, sample 1 ns after the edge.
   task automatic step(input logic [15:0] k, input logic p,
                       input logic c);
      logic [7:0] kb;
      bit ev;
      kb = k[7:0];
      key_in = k;
      pop = p;
      ovf_clear = c;
      ev = 0;
      if (kb == 8'h00) begin
         m_t = 0;
      end else if (kb != m_prev) begin
         ev = 1;
         m_t = 0;
      end else begin
         m_t++;
         if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0)) ev = 1;
      end
      if (p && m_q.size() > 0) void'(m_q.pop_front());
      if (ev && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (ev && m_q.size() < DEPTH) m_q.push_back(kb);
      m_prev = kb;
      @(posedge clk);
      #1;
      pop = 1'b0;
      ovf_clear = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      key_in = 16'h0;
      pop = 1'b0;
      ovf_clear = 1'b0;
      m_reset();
      #23;
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) step(16'h0, 0, 0);
      n_tests++;
      if ({out, empty, full, overflow} !== {16'h0, 3'b100}) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h",
                  {out, empty, full, overflow}, {16'h0, 3'b100});
      end
   endtask

   task automatic test_repeat();
      int pushes;
      pushes = 0;
      for (int i = 0; i < 40; i++) begin
         step(16'h0061, 0, 0);
         n_tests++;
         if ({out, empty, full, overflow} !== m_exp()) begin
            n_fail++;
            $display("FAIL repeat_cyc%0d got=%h exp=%h", i,
                     {out, empty, full, overflow}, m_exp());
         end
      end
      step(16'h0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if ({out, empty} !== {16'h0061, 1'b0}) begin
            n_fail++;
            $display("FAIL repeat_pop%0d got=%h/%b exp=0061/0",
                     i, out, empty);
         end
         step(16'h0, 1, 0);
      end
      n_tests++;
      if ({out, empty} !== {16'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL repeat_drained got=%h/%b exp=0000/1",
                  out, empty);
      end
   endtask

   task automatic test_rollover();
      for (int i = 0; i < 3; i++) step(16'h0061, 0, 0);
      for (int i = 0; i < 3; i++) step(16'h0062, 0, 0);
      step(16'h0, 0, 0);
      step(16'h0, 0, 0);
      n_tests++;
      if (out !== 16'h0061) begin
         n_fail++;
         $display("FAIL rollover_first got=%h exp=0061", out);
      end
      step(16'h0, 1, 0);
      n_tests++;
      if (out !== 16'h0062) begin
         n_fail++;
         $display("FAIL rollover_second got=%h exp=0062", out);
      end
      step(16'h0, 1, 0);
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL rollover_norelease got=%b exp=1", empty);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) begin
         step({8'h00, 8'h10 + 8'(i)}, 0, 0);
         if (i == 7) begin
            n_tests++;
            if ({full, overflow} !== 2'b10) begin
               n_fail++;
               $display("FAIL ovf_full8 got=%b%b exp=10", full, overflow);
            end
         end
         step(16'h0, 0, 0);
      end
      n_tests++;
      if ({full, overflow} !== 2'b11) begin
         n_fail++;
         $display("FAIL ovf_drop9 got=%b%b exp=11", full, overflow);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (out !== {8'h00, 8'h10 + 8'(i)}) begin
            n_fail++;
            $display("FAIL ovf_pop%0d got=%h exp=%h", i, out,
                     {8'h00, 8'h10 + 8'(i)});
         end
         step(16'h0, 1, 0);
      end
      n_tests++;
      if ({empty, overflow} !== 2'b11) begin
         n_fail++;
         $display("FAIL ovf_sticky got=%b%b exp=11", empty, overflow);
      end
      step(16'h0, 0, 1);
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear got=%b exp=0", overflow);
      end
   endtask

   task automatic test_push_pop_same_cycle();
      for (int i = 0; i < 8; i++) begin
         step({8'h00, 8'h40 + 8'(i)}, 0, 0);
         step(16'h0, 0, 0);
      end
      step(16'h0048, 1, 0);
      n_tests++;
      if ({out, full, overflow} !== {16'h0041, 2'b10}) begin
         n_fail++;
         $display("FAIL full_pushpop got=%h/%b%b exp=0041/10",
                  out, full, overflow);
      end
      step(16'h0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (out !== {8'h00, 8'h41 + 8'(i)}) begin
            n_fail++;
            $display("FAIL full_pushpop_pop%0d got=%h exp=%h", i, out,
                     {8'h00, 8'h41 + 8'(i)});
         end
         step(16'h0, 1, 0);
      end
      step(16'h0, 1, 0);
      n_tests++;
      if ({out, empty, full, overflow} !== {16'h0, 3'b100}) begin
         n_fail++;
         $display("FAIL empty_pop got=%h exp=%h",
                  {out, empty, full, overflow}, {16'h0, 3'b100});
      end
      step(16'h0070, 1, 0);
      n_tests++;
      if ({out, empty} !== {16'h0070, 1'b0}) begin
         n_fail++;
         $display("FAIL empty_pushpop got=%h/%b exp=0070/0", out, empty);
      end
      step(16'h0, 1, 0);
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_pushpop_cnt1 got=%b exp=1", empty);
      end
   endtask

   task automatic test_random();
      logic [7:0] keys [4];
      logic [15:0] k;
      int hold;
      keys[0] = 8'h00;
      keys[1] = 8'h31;
      keys[2] = 8'h32;
      keys[3] = 8'h33;
      hold = 0;
      k = 16'h0;
      for (int i = 0; i < 500; i++) begin
         if (hold == 0) begin
            k = {8'($urandom), keys[$urandom_range(0, 3)]};
            hold = $urandom_range(1, 40);
         end
         hold--;
         step(k, ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
         n_tests++;
         if ({out, empty, full, overflow} !== m_exp()) begin
            n_fail++;
            $display("FAIL random_cyc%0d got=%h exp=%h", i,
                     {out, empty, full, overflow}, m_exp());
         end
      end
   endtask

   task automatic test_async_reset();
      while (m_q.size() > 0) step(16'h0, 1, 0);
      step(16'h0, 0, 1);
      for (int i = 0; i < 27; i++) step(16'h0055, 0, 0);
      n_tests++;
      if ({out, empty} !== {16'h0055, 1'b0}) begin
         n_fail++;
         $display("FAIL arst_pre got=%h/%b exp=0055/0", out, empty);
      end
      #3;
      resetn = 1'b0;
      m_reset();
      #1;
      n_tests++;
      if ({out, empty, full, overflow} !== {16'h0, 3'b100}) begin
         n_fail++;
         $display("FAIL arst_async got=%h exp=%h",
                  {out, empty, full, overflow}, {16'h0, 3'b100});
      end
      #2;
      resetn = 1'b1;
      step(16'h0055, 0, 0);
      n_tests++;
      if ({out, empty} !== {16'h0055, 1'b0}) begin
         n_fail++;
         $display("FAIL arst_fresh got=%h/%b exp=0055/0", out, empty);
      end
      step(16'h0055, 1, 0);
      for (int i = 0; i < 18; i++) step(16'h0055, 0, 0);
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_delay_early got=%b exp=1", empty);
      end
      step(16'h0055, 0, 0);
      n_tests++;
      if ({out, empty, full, overflow} !== m_exp()) begin
         n_fail++;
         $display("FAIL arst_first_repeat got=%h exp=%h",
                  {out, empty, full, overflow}, m_exp());
      end
      n_tests++;
      if ({out, empty} !== {16'h0055, 1'b0}) begin
         n_fail++;
         $display("FAIL arst_repeat_at20 got=%h/%b exp=0055/0",
                  out, empty);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_repeat();
      test_rollover();
      test_overflow();
      test_push_pop_same_cycle();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
